pixel_adc_cell: RTL and testbench

//  Digital behavioural model of one pixel's in-pixel single-slope ADC and bus driver. It is the

---
 rtl/pixel_pkg.sv | 16 +
 rtl/pixel_sat_counter.sv | 34 +++
 rtl/pixel_adc_cell.sv | 153 +++++++++++++++
 tb/tb_pixel_adc_cell.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared types and defaults for the in-pixel single-slope ADC cell.
package pixel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERASED,
        EXPOSE,
        CONVERT,
        HOLD,
        READ
    } pix_state_t;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned LEVEL_W_DEF = 8;

endpackage

// File: rtl/pixel_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module pixel_sat_counter #(
    parameter int unsigned LEVEL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [LEVEL_W-1:0] value
);

    logic [LEVEL_W-1:0] value_q;
    logic [LEVEL_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && !(&value_q)) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pixel_adc_cell.sv
// One pixel's single-slope ADC: integrate on expose, latch the bus ramp code on trip,
// and drive the stored code back onto the shared bus during read.
module pixel_adc_cell
    import pixel_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned LEVEL_W = LEVEL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              erase,
    input  logic              expose,
    input  logic              convert,
    input  logic              read,
    input  logic              bias_tick,
    input  logic              ramp_tick,
    inout  wire  [DATA_W-1:0] data,
    output logic              tripped,
    output logic              phase_err
);

    pix_state_t state_q, state_d;
    logic [DATA_W-1:0] mem_q, mem_d;
    logic tripped_q, tripped_d;
    logic phase_err_q, phase_err_d;

    logic [LEVEL_W-1:0] int_lvl;
    logic [LEVEL_W-1:0] ramp_lvl;
    logic int_clr, int_inc;
    logic ramp_clr, ramp_inc;

    logic multi_phase;
    logic eff_expose, eff_convert, eff_read, no_phase;
    logic bus_drive;

    // Priority-resolved phase: erase > expose > convert > read
    assign eff_expose  = expose & ~erase;
    assign eff_convert = convert & ~erase & ~expose;
    assign eff_read    = read & ~erase & ~expose & ~convert;
    assign no_phase    = ~(erase | expose | convert | read);
    assign multi_phase = (erase & (expose | convert | read)) |
                         (expose & (convert | read)) |
                         (convert & read);

    pixel_sat_counter #(
        .LEVEL_W(LEVEL_W)
    ) u_int_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (int_clr),
        .inc  (int_inc),
        .value(int_lvl)
    );

    pixel_sat_counter #(
        .LEVEL_W(LEVEL_W)
    ) u_ramp_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (ramp_clr),
        .inc  (ramp_inc),
        .value(ramp_lvl)
    );

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        tripped_d   = tripped_q;
        phase_err_d = phase_err_q | multi_phase;
        int_clr     = 1'b0;
        int_inc     = 1'b0;
        ramp_clr    = 1'b0;
        ramp_inc    = 1'b0;

        if (erase) begin
            state_d   = ERASED;
            int_clr   = 1'b1;
            ramp_clr  = 1'b1;
            mem_d     = '0;
            tripped_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                ERASED: begin
                    if (eff_expose) begin
                        state_d = EXPOSE;
                    end
                end
                EXPOSE: begin
                    if (eff_expose) begin
                        int_inc = bias_tick;
                    end else if (eff_convert) begin
                        state_d   = CONVERT;
                        ramp_clr  = 1'b1;
                        tripped_d = 1'b0;
                    end
                end
                CONVERT: begin
                    if (eff_convert) begin
                        // Compare uses pre-increment ramp level
                        if (!tripped_q && (ramp_lvl >= int_lvl)) begin
                            mem_d     = data;
                            tripped_d = 1'b1;
                        end
                        ramp_inc = ramp_tick;
                    end else if (no_phase) begin
                        state_d = HOLD;
                        if (!tripped_q) begin
                            mem_d = data;
                        end
                        tripped_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (eff_read) begin
                        state_d = READ;
                    end
                end
                READ: begin
                    if (!read) begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_q       <= '0;
            tripped_q   <= 1'b0;
            phase_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            tripped_q   <= tripped_d;
            phase_err_q <= phase_err_d;
        end
    end

    // Driven only from registered state, so the first read edge still sees the bus released
    assign bus_drive = (state_q == READ);
    assign data      = bus_drive ? mem_q : {DATA_W{1'bz}};

    assign tripped   = tripped_q;
    assign phase_err = phase_err_q;

endmodule

// File: tb/tb_pixel_adc_cell.sv
// Directed self-checking bench for pixel_adc_cell.
module tb_pixel_adc_cell;
    import pixel_pkg::*;

    logic       clk;
    logic       reset;
    logic       erase, expose, convert, read;
    logic       bias_tick, ramp_tick;
    logic       tripped, phase_err;
    logic       tb_drive;
    logic [7:0] tb_bus;
    wire  [7:0] data;

    int n_cmp;
    int n_bad;

    assign data = tb_drive ? tb_bus : 8'bz;

    pixel_adc_cell #(
        .DATA_W (8),
        .LEVEL_W(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .erase    (erase),
        .expose   (expose),
        .convert  (convert),
        .read     (read),
        .bias_tick(bias_tick),
        .ramp_tick(ramp_tick),
        .data     (data),
        .tripped  (tripped),
        .phase_err(phase_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (dut.state_q !== IDLE) begin
            n_bad++;
            $display("FAIL reset_state got=%0d want=%0d", dut.state_q, IDLE);
        end
        n_cmp++;
        if (tripped !== 1'b0 || phase_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags got=%b%b want=00", tripped, phase_err);
        end
        n_cmp++;
        if (dut.bus_drive !== 1'b0 || dut.mem_q !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_bus drive=%b mem=%0d want drive=0 mem=0", dut.bus_drive, dut.mem_q);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int trip_k;
        trip_k = -1;
        erase = 1'b1;
        tick();
        erase = 1'b0;
        n_cmp++;
        if (dut.state_q !== ERASED) begin
            n_bad++;
            $display("FAIL basic_erased got=%0d want=%0d", dut.state_q, ERASED);
        end
        expose = 1'b1;
        tick();
        bias_tick = 1'b1;
        repeat (20) tick();
        bias_tick = 1'b0;
        expose = 1'b0;
        n_cmp++;
        if (dut.int_lvl !== 8'd20) begin
            n_bad++;
            $display("FAIL basic_int got=%0d want=20", dut.int_lvl);
        end
        convert = 1'b1;
        ramp_tick = 1'b1;
        tb_drive = 1'b1;
        tb_bus = 8'd0;
        tick();
        for (int k = 0; k < 40; k++) begin
            tb_bus = 8'(k + 1);
            tick();
            if (tripped === 1'b1 && trip_k < 0) trip_k = k;
        end
        convert = 1'b0;
        ramp_tick = 1'b0;
        tb_bus = 8'hAA;
        tick();
        tb_drive = 1'b0;
        n_cmp++;
        if (trip_k !== 20) begin
            n_bad++;
            $display("FAIL basic_trip_k got=%0d want=20", trip_k);
        end
        n_cmp++;
        if (dut.mem_q !== 8'd21 || tripped !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_mem got=%0d/%b want=21/1", dut.mem_q, tripped);
        end
        n_cmp++;
        if (dut.state_q !== HOLD) begin
            n_bad++;
            $display("FAIL basic_hold got=%0d want=%0d", dut.state_q, HOLD);
        end
    endtask

    task automatic test_readback();
        read = 1'b1;
        n_cmp++;
        if (dut.bus_drive !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_turnon got drive=%b want 0", dut.bus_drive);
        end
        tick();
        n_cmp++;
        if (dut.bus_drive !== 1'b1 || data !== 8'd21) begin
            n_bad++;
            $display("FAIL rd_first got drive=%b data=%0d want 1/21", dut.bus_drive, data);
        end
        tick();
        tick();
        n_cmp++;
        if (data !== 8'd21 || tripped !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_hold got data=%0d tripped=%b want 21/1", data, tripped);
        end
        read = 1'b0;
        tick();
        n_cmp++;
        if (dut.bus_drive !== 1'b0 || dut.state_q !== HOLD) begin
            n_bad++;
            $display("FAIL rd_release got drive=%b state=%0d want 0/%0d", dut.bus_drive,
                     dut.state_q, HOLD);
        end
    endtask

    task automatic test_dark();
        erase = 1'b1;
        tick();
        erase = 1'b0;
        expose = 1'b1;
        tick();
        expose = 1'b0;
        convert = 1'b1;
        ramp_tick = 1'b1;
        tb_drive = 1'b1;
        tb_bus = 8'd0;
        tick();
        tb_bus = 8'd1;
        tick();
        n_cmp++;
        if (tripped !== 1'b1 || dut.mem_q !== 8'd1) begin
            n_bad++;
            $display("FAIL dark_trip got=%b/%0d want=1/1", tripped, dut.mem_q);
        end
        tb_bus = 8'd2;
        tick();
        convert = 1'b0;
        ramp_tick = 1'b0;
        tb_bus = 8'd9;
        tick();
        tb_drive = 1'b0;
        n_cmp++;
        if (dut.mem_q !== 8'd1 || dut.state_q !== HOLD) begin
            n_bad++;
            $display("FAIL dark_once got mem=%0d state=%0d want 1/%0d", dut.mem_q, dut.state_q,
                     HOLD);
        end
    endtask

    task automatic test_saturation();
        erase = 1'b1;
        tick();
        erase = 1'b0;
        expose = 1'b1;
        tick();
        bias_tick = 1'b1;
        repeat (300) tick();
        bias_tick = 1'b0;
        expose = 1'b0;
        n_cmp++;
        if (dut.int_lvl !== 8'd255) begin
            n_bad++;
            $display("FAIL sat_int got=%0d want=255", dut.int_lvl);
        end
        convert = 1'b1;
        ramp_tick = 1'b1;
        tb_drive = 1'b1;
        tb_bus = 8'd0;
        tick();
        for (int k = 0; k < 9; k++) begin
            tb_bus = 8'(k + 1);
            tick();
        end
        n_cmp++;
        if (tripped !== 1'b0 || dut.ramp_lvl !== 8'd9) begin
            n_bad++;
            $display("FAIL sat_notrip got tripped=%b ramp=%0d want 0/9", tripped, dut.ramp_lvl);
        end
        convert = 1'b0;
        ramp_tick = 1'b0;
        tb_bus = 8'd10;
        tick();
        tb_drive = 1'b0;
        n_cmp++;
        if (dut.mem_q !== 8'd10 || tripped !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_exit got mem=%0d tripped=%b want 10/1", dut.mem_q, tripped);
        end
    endtask

    task automatic test_conflicts();
        read = 1'b1;
        tick();
        n_cmp++;
        if (phase_err !== 1'b0) begin
            n_bad++;
            $display("FAIL cf_noerr got=%b want=0", phase_err);
        end
        erase = 1'b1;
        tick();
        erase = 1'b0;
        read = 1'b0;
        n_cmp++;
        if (dut.state_q !== ERASED || phase_err !== 1'b1 || dut.bus_drive !== 1'b0) begin
            n_bad++;
            $display("FAIL cf_erase_read got state=%0d err=%b drive=%b want %0d/1/0",
                     dut.state_q, phase_err, dut.bus_drive, ERASED);
        end
        convert = 1'b1;
        tick();
        convert = 1'b0;
        tick();
        n_cmp++;
        if (dut.state_q !== ERASED || phase_err !== 1'b1) begin
            n_bad++;
            $display("FAIL cf_conv_ignored got state=%0d err=%b want %0d/1", dut.state_q,
                     phase_err, ERASED);
        end
        expose = 1'b1;
        convert = 1'b1;
        tick();
        expose = 1'b0;
        convert = 1'b0;
        n_cmp++;
        if (dut.state_q !== EXPOSE) begin
            n_bad++;
            $display("FAIL cf_prio got=%0d want=%0d", dut.state_q, EXPOSE);
        end
    endtask

    task automatic test_reset_mid_read();
        convert = 1'b1;
        tb_drive = 1'b1;
        tb_bus = 8'h00;
        tick();
        tb_bus = 8'h5A;
        tick();
        convert = 1'b0;
        tb_bus = 8'h11;
        tick();
        tb_drive = 1'b0;
        read = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (data !== 8'h5A) begin
            n_bad++;
            $display("FAIL rst_pre got=%0h want=5a", data);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (dut.bus_drive !== 1'b0 || dut.state_q !== IDLE || dut.mem_q !== 8'd0) begin
            n_bad++;
            $display("FAIL rst_mid got drive=%b state=%0d mem=%0d want 0/%0d/0", dut.bus_drive,
                     dut.state_q, dut.mem_q, IDLE);
        end
        n_cmp++;
        if (phase_err !== 1'b0 || tripped !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_flags got err=%b tripped=%b want 0/0", phase_err, tripped);
        end
        read = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        erase = 1'b0;
        expose = 1'b0;
        convert = 1'b0;
        read = 1'b0;
        bias_tick = 1'b0;
        ramp_tick = 1'b0;
        tb_drive = 1'b0;
        tb_bus = 8'd0;
        test_reset();
        test_basic();
        test_readback();
        test_dark();
        test_saturation();
        test_conflicts();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
